couleur_arbitre: RTL

Registered per-pixel layer arbiter and palette decoder that sits between the three colour sources (cadre, pave, pesanteur) and the VGA DAC pins. It selects one 5-bit colour index per active pixel according to a frame-synchronous priority mode, optionally blinks the pesanteur layer, and flags pave/pesanteur overlap per frame. It drives 3-3-2 RGB with a fixed two-cycle latency.

---
 rtl/couleur_arbitre.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/couleur_arbitre.sv
// couleur_arbitre: registered cadre/pave/pesanteur layer arbiter with a 3-3-2 palette decoder.
// Two-cycle latency. Define COULEUR_BLINK_EN to build the frame-synchronous pesanteur blink.
`timescale 1ns/1ps
module couleur_arbitre #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [1:0]  PRIO_RESET   = 2'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_valid,
    input  logic       frame_start,
    input  logic [4:0] couleur_cadre,
    input  logic [4:0] couleur_pave,
    input  logic [4:0] couleur_pesanteur,
    input  logic [2:0] layer_en,
    input  logic [1:0] cfg_prio,
    input  logic       blink_on,
    output logic [2:0] rouge,
    output logic [2:0] vert,
    output logic [1:0] bleu,
    output logic       out_valid,
    output logic       collision_frame
);

    typedef enum logic [1:0] {
        PRIO_PES_PAVE_CADRE   = 2'd0,
        PRIO_PAVE_PES_CADRE   = 2'd1,
        PRIO_CADRE_PES_PAVE   = 2'd2,
        PRIO_PES_PAVE_CADRE_B = 2'd3
    } prio_e;

    logic [4:0] w_cadre;
    logic [4:0] w_pave;
    logic [4:0] w_pes;
    logic [4:0] w_pes_vis;
    logic [4:0] w_sel;
    logic       w_collision;
    logic       w_hide;

    prio_e      r_prio;
    logic       r_sticky;
    logic       r_collision_frame;
    logic [4:0] r_idx;
    logic       r_valid1;
    logic [2:0] r_rouge;
    logic [2:0] r_vert;
    logic [1:0] r_bleu;
    logic       r_out_valid;

    assign w_cadre     = layer_en[0] ? couleur_cadre     : 5'd0;
    assign w_pave      = layer_en[1] ? couleur_pave      : 5'd0;
    assign w_pes       = layer_en[2] ? couleur_pesanteur : 5'd0;
    // Overlap is judged on the masked layers, before blink hides pesanteur.
    assign w_collision = pixel_valid && (w_pave != 5'd0) && (w_pes != 5'd0);
    assign w_pes_vis   = w_hide ? 5'd0 : w_pes;

`ifdef COULEUR_BLINK_EN
    localparam logic [5:0] CNT_LAST = 6'(BLINK_FRAMES - 1);

    logic [5:0] r_frame_cnt;
    logic       r_phase;
    logic       r_blink_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_q   <= 1'b0;
            r_frame_cnt <= 6'd0;
            r_phase     <= 1'b0;
        end else begin
            if (frame_start) begin
                r_blink_q <= blink_on;
            end
            // Counting follows the blink state of the closing frame, so the enabling pulse is not counted.
            if (!r_blink_q) begin
                r_frame_cnt <= 6'd0;
                r_phase     <= 1'b0;
            end else if (frame_start) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= 6'd0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end
        end
    end

    assign w_hide = r_blink_q & r_phase;
`else
    logic [6:0] w_unused_blink;
    assign w_unused_blink = {blink_on, 6'(BLINK_FRAMES)};
    assign w_hide         = 1'b0;
`endif

    function automatic logic [4:0] first_opaque(input logic [4:0] a, input logic [4:0] b,
                                                 input logic [4:0] c);
        if (a != 5'd0) begin
            first_opaque = a;
        end else if (b != 5'd0) begin
            first_opaque = b;
        end else begin
            first_opaque = c;
        end
    endfunction

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        w_sel = 5'd0;
        case (r_prio)
            PRIO_PAVE_PES_CADRE: w_sel = first_opaque(w_pave, w_pes_vis, w_cadre);
            PRIO_CADRE_PES_PAVE: w_sel = first_opaque(w_cadre, w_pes_vis, w_pave);
            default:             w_sel = first_opaque(w_pes_vis, w_pave, w_cadre);
        endcase
    end

    function automatic logic [2:0] rg_level(input logic [1:0] d);
        case (d)
            2'd0:    rg_level = 3'b000;
            2'd1:    rg_level = 3'b011;
            default: rg_level = 3'b111;
        endcase
    endfunction

    function automatic logic [1:0] b_level(input logic [1:0] d);
        case (d)
            2'd0:    b_level = 2'b00;
            2'd1:    b_level = 2'b01;
            default: b_level = 2'b11;
        endcase
    endfunction

    // Base-3 digits are taken from the index itself: 1 is the darkest blue, 26 is white.
    function automatic logic [7:0] palette(input logic [4:0] idx);
        logic [4:0] q3;
        logic [1:0] d_r;
        logic [1:0] d_g;
        logic [1:0] d_b;
        q3      = idx / 5'd3;
        d_r     = 2'(idx / 5'd9);
        d_g     = 2'(q3 % 5'd3);
        d_b     = 2'(idx % 5'd3);
        palette = 8'd0;
        if ((idx != 5'd0) && (idx <= 5'd26)) begin
            palette = {rg_level(d_r), rg_level(d_g), b_level(d_b)};
        end
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= 5'd0;
            r_valid1    <= 1'b0;
            r_rouge     <= 3'd0;
            r_vert      <= 3'd0;
            r_bleu      <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_idx       <= w_sel;
            r_valid1    <= pixel_valid;
            r_out_valid <= r_valid1;
            {r_rouge, r_vert, r_bleu} <= r_valid1 ? palette(r_idx) : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio            <= prio_e'(PRIO_RESET);
            r_sticky          <= 1'b0;
            r_collision_frame <= 1'b0;
        end else if (frame_start) begin
            r_prio            <= prio_e'(cfg_prio);
            r_collision_frame <= r_sticky;
            r_sticky          <= w_collision;
        end else if (w_collision) begin
            r_sticky          <= 1'b1;
        end
    end

    assign rouge           = r_rouge;
    assign vert            = r_vert;
    assign bleu            = r_bleu;
    assign out_valid       = r_out_valid;
    assign collision_frame = r_collision_frame;

endmodule
